// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder.
// Keeps the PC and issues in-order word requests to instruction memory. Returned
// words are buffered with their PCs in a small FIFO. A redirect flushes the FIFO,
// marks every in-flight request as stale and restarts fetch at the new PC.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   imem_req_valid/ready/addr         fetch request channel (addr word aligned)
//   imem_resp_valid/data              in-order response, one per accepted request
//   redirect_valid/pc                 flush and restart fetch (pc[1:0] ignored)
//   instr_valid/ready, instr/instr_pc decoder handshake, FIFO head
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] out_q, out_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [PTR_W-1:0] f_rd_q, f_rd_d, f_wr_q, f_wr_d;
    logic [PTR_W-1:0] pq_rd_q, pq_rd_d, pq_wr_q, pq_wr_d;
    logic [31:0]      fifo_word_q [DEPTH];
    logic [31:0]      fifo_pc_q   [DEPTH];
    logic [31:0]      pcq_q       [DEPTH];

    logic [SUM_W-1:0] used_c;
    logic             req_fire_c, resp_fire_c, resp_drop_c, push_c, pop_c;

    // Credits: in-flight requests plus buffered words never exceed DEPTH.
    assign used_c         = SUM_W'(out_q) + SUM_W'(cnt_q);
    assign imem_req_valid = rst_n && !redirect_valid && (used_c < SUM_W'(DEPTH));
    assign imem_req_addr  = pc_q;
    assign req_fire_c     = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp_fire_c = imem_resp_valid && (out_q != '0);
    assign resp_drop_c = resp_fire_c && (drop_q != '0);
    assign push_c      = resp_fire_c && !resp_drop_c && !redirect_valid;
    assign pop_c       = (cnt_q != '0) && instr_ready && !redirect_valid;

    assign instr_valid = (cnt_q != '0);
    assign instr       = fifo_word_q[f_rd_q];
    assign instr_pc    = fifo_pc_q[f_rd_q];

    // Next-state for PC, counters and pointers; redirect overrides everything.
    always_comb begin
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        out_d   = out_q - CNT_W'(resp_fire_c);
        drop_d  = drop_q;
        f_rd_d  = f_rd_q;
        f_wr_d  = f_wr_q;
        pq_wr_d = pq_wr_q;
        pq_rd_d = resp_fire_c ? PTR_W'(pq_rd_q + PTR_W'(1)) : pq_rd_q;

        if (redirect_valid) begin
            pc_d   = redirect_pc & 32'hFFFF_FFFC;
            cnt_d  = '0;
            f_wr_d = f_rd_q;
            // Every request still in flight after this cycle is now stale.
            drop_d = out_q - CNT_W'(resp_fire_c);
        end else begin
            if (req_fire_c) begin
                pc_d    = pc_q + 32'd4;
                out_d   = out_q + CNT_W'(1) - CNT_W'(resp_fire_c);
                pq_wr_d = PTR_W'(pq_wr_q + PTR_W'(1));
            end
            drop_d = drop_q - CNT_W'(resp_drop_c);
            cnt_d  = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
            if (push_c) f_wr_d = PTR_W'(f_wr_q + PTR_W'(1));
            if (pop_c)  f_rd_d = PTR_W'(f_rd_q + PTR_W'(1));
        end
    end

    // State and storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            out_q   <= '0;
            drop_q  <= '0;
            f_rd_q  <= '0;
            f_wr_q  <= '0;
            pq_rd_q <= '0;
            pq_wr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_word_q[i] <= '0;
                fifo_pc_q[i]   <= '0;
                pcq_q[i]       <= '0;
            end
        end else begin
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            drop_q  <= drop_d;
            f_rd_q  <= f_rd_d;
            f_wr_q  <= f_wr_d;
            pq_rd_q <= pq_rd_d;
            pq_wr_q <= pq_wr_d;
            if (req_fire_c) pcq_q[pq_wr_q] <= pc_q;
            if (push_c) begin
                fifo_word_q[f_wr_q] <= imem_resp_data;
                fifo_pc_q[f_wr_q]   <= pcq_q[pq_rd_q];
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a behavioural instruction
// memory (fixed latency, returns the inverted address as data) and an expected
// next-PC tracker that checks every instruction the decoder side consumes.
module tb_fetch_unit;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    int          cyc = 0;
    int          lat = 1;
    int          nvec = 0;
    int          nfail = 0;
    int          npop = 0;
    int          nacc = 0;
    logic [31:0] exp_pc = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic tick();
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = ~mq[0].addr;
            void'(mq.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
        end
        #1;
        if (redirect_valid) chk("req_valid_during_redirect", 32'(imem_req_valid), 32'd0);
        if (imem_req_valid && imem_req_ready) begin
            mq.push_back('{addr: imem_req_addr, due: cyc + lat});
            nacc++;
        end
        if (instr_valid && instr_ready && !redirect_valid) begin
            chk("instr_pc", instr_pc, exp_pc);
            chk("instr_word", instr, ~exp_pc);
            exp_pc = exp_pc + 32'd4;
            npop++;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        redirect_valid  = 1'b0;
        imem_resp_valid = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        exp_pc         = target & 32'hFFFF_FFFC;
        tick();
        chk("instr_valid_after_redirect", 32'(instr_valid), 32'd0);
        chk("addr_after_redirect", imem_req_addr, target & 32'hFFFF_FFFC);
    endtask

    initial begin
        int          p0, a0;
        logic        cap, found;
        logic [31:0] hpc, hw;

        // Reset values while held in reset.
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("first_req_addr", imem_req_addr, 32'h0);

        // Streaming with 1-cycle memory.
        exp_pc = 32'h0;
        for (int i = 0; i < 20; i++) tick();
        chk("stream_pop_count", 32'(npop >= 10), 32'd1);

        // Decoder stall: bounded acceptance, held head, then resume.
        instr_ready = 1'b0;
        a0  = nacc;
        cap = 1'b0;
        hpc = '0;
        hw  = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (instr_valid) begin
                if (!cap) begin
                    cap = 1'b1;
                    hpc = instr_pc;
                    hw  = instr;
                end else begin
                    chk("stall_pc_stable", instr_pc, hpc);
                    chk("stall_word_stable", instr, hw);
                end
            end
        end
        chk("stall_accepts_le_depth", 32'(nacc - a0 <= int'(DEPTH)), 32'd1);
        chk("stall_req_valid_low", 32'(imem_req_valid), 32'd0);
        chk("stall_instr_valid", 32'(instr_valid), 32'd1);
        chk("stall_head_is_next", instr_pc, exp_pc);
        instr_ready = 1'b1;
        p0 = npop;
        for (int i = 0; i < 15; i++) tick();
        chk("resume_pop_count", 32'(npop - p0 >= 6), 32'd1);

        // Redirect with two requests in flight, 3-cycle memory.
        lat   = 3;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (mq.size() == 2) found = 1'b1;
            else tick();
        end
        chk("two_in_flight_found", 32'(found), 32'd1);
        redirect(32'h0000_0103);
        p0 = npop;
        for (int i = 0; i < 20; i++) tick();
        chk("redirect_103_pops", 32'(npop - p0 >= 3), 32'd1);

        // Redirect coinciding with a response and a pop.
        lat   = 1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (instr_valid && mq.size() > 0 && mq[0].due <= cyc) found = 1'b1;
            else tick();
        end
        chk("resp_pop_cycle_found", 32'(found), 32'd1);
        redirect(32'h0000_0200);
        p0 = npop;
        for (int i = 0; i < 15; i++) tick();
        chk("redirect_200_pops", 32'(npop - p0 >= 5), 32'd1);

        // Back-to-back redirects, then wrap past the top of memory.
        redirect(32'h0000_0400);
        redirect(32'hFFFF_FFF8);
        p0 = npop;
        for (int i = 0; i < 15; i++) tick();
        chk("wrap_pops", 32'(npop - p0 >= 3), 32'd1);
        chk("wrap_reached_low", 32'(exp_pc < 32'h100), 32'd1);

        // Asynchronous reset mid-stream with requests outstanding.
        lat   = 3;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (mq.size() > 0) found = 1'b1;
            else tick();
        end
        chk("outstanding_before_reset", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("mid_rst_req_addr", imem_req_addr, 32'h0);
        chk("mid_rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("mid_rst_instr", instr, 32'h0);
        chk("mid_rst_instr_pc", instr_pc, 32'h0);
        mq.delete();
        @(negedge clk);
        rst_n  = 1'b1;
        exp_pc = 32'h0;
        #1;
        chk("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
        chk("post_rst_req_addr", imem_req_addr, 32'h0);
        p0 = npop;
        for (int i = 0; i < 20; i++) tick();
        chk("post_rst_pops", 32'(npop - p0 >= 3), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
